// File: rtl/rca_chk_pkg.sv
// Shared types for the ripple-carry adder sum checker.
// State encoding, default widths and the stage-1 beat layout.
package rca_chk_pkg;

  localparam int WIDTH_D = 4;
  localparam int CNT_W_D = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [WIDTH_D-1:0] a;
    logic [WIDTH_D-1:0] b;
    logic               c;
    logic [WIDTH_D:0]   s;
    logic [CNT_W_D-1:0] idx;
  } beat_t;

endpackage

// File: rtl/rca_chk_satcnt.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module rca_chk_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/rca_sum_checker.sv
// Streaming self-check of a ripple-carry adder's sum output.
// Optional first-fail capture: define RCA_CHK_FIRST_FAIL_EN.
module rca_sum_checker
  import rca_chk_pkg::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int NUM_VEC = 20,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic [WIDTH:0]   in_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             mism_valid,
  output logic [CNT_W-1:0] mism_idx
`ifdef RCA_CHK_FIRST_FAIL_EN
  ,
  output logic               ff_valid,
  output logic [CNT_W-1:0]   ff_idx,
  output logic [3*WIDTH+1:0] ff_data
`endif
);

  localparam int SW = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH:0]   s;
    logic [CNT_W-1:0] idx;
  } stg_t;

  state_t st, st_nx;
  logic   s1_v;
  stg_t   s1;
  logic   acc, clr, last, bad;
  logic [WIDTH:0] exp_s;

  assign in_ready = (st == RUN);
  assign busy     = (st == RUN) || (st == DRAIN);
  assign done     = (st == DONE);
  assign pass     = done && (err_cnt == '0);

  assign acc  = in_valid && in_ready;
  assign clr  = start && ((st == IDLE) || (st == DONE));
  assign last = acc && (vec_cnt == CNT_W'(NUM_VEC - 1));

  assign exp_s = SW'(s1.a) + SW'(s1.b) + SW'(s1.c);
  assign bad   = s1_v && (exp_s != s1.s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  // DRAIN ends once stage 1 has emptied into the compare register
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (start) st_nx = RUN;
      RUN:     if (last) st_nx = DRAIN;
      DRAIN:   if (!s1_v) st_nx = DONE;
      DONE:    if (start) st_nx = RUN;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s1         <= '0;
      mism_valid <= 1'b0;
      mism_idx   <= '0;
    end else begin
      s1_v       <= acc;
      mism_valid <= bad;
      if (acc) begin
        s1 <= '{a: in_a, b: in_b, c: in_c,
                s: in_s, idx: vec_cnt};
      end
      if (bad) begin
        mism_idx <= s1.idx;
      end
    end
  end

  rca_chk_satcnt #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (acc),
    .q     (vec_cnt)
  );

  rca_chk_satcnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (bad),
    .q     (err_cnt)
  );

`ifdef RCA_CHK_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_data  <= '0;
    end else if (clr) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_data  <= '0;
    end else if (bad && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_idx   <= s1.idx;
      ff_data  <= {s1.a, s1.b, s1.c, s1.s};
    end
  end
`endif

endmodule

// File: doc/rca_sum_checker.md
Name: rca_sum_checker

Overview:
- Streaming self-check stage directly downstream of the 4-bit ripple-carry adder.
- Consumes each operand triple (a, b, cin) together with the adder's 5-bit sum through a valid/ready handshake.
- Recomputes the expected sum, compares it against the adder's sum, and counts vectors and mismatches over a programmed run of NUM_VEC vectors.
- Reports done/pass status for the lab sign-off flow.

Parameters:
- WIDTH, 4, operand width; the sum is WIDTH+1 bits.
- NUM_VEC, 20, vectors accepted per run (1..2**CNT_W-1).
- CNT_W, 8, width of the vector and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  the operand/sum beat is valid.
- in_ready  out  1  the checker accepts a beat this cycle.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_c  in  1  carry-in.
- in_s  in  WIDTH+1  adder sum under check.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high; 1 means err_cnt==0.
- vec_cnt  out  CNT_W  number of beats accepted this run.
- err_cnt  out  CNT_W  mismatches this run; saturates at all-ones.
- mism_valid  out  1  one-cycle pulse on a detected mismatch.
- mism_idx  out  CNT_W  index (0-based) of the vector that mismatched; valid with mism_valid.

Behaviour:
- Reset (rst_n=0, takes effect immediately): state=IDLE. in_ready, busy, done, pass, mism_valid are 0. vec_cnt, err_cnt, mism_idx are 0. Pipeline valid bits are cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start. On entry, vec_cnt and err_cnt clear.
- RUN:
  - in_ready=1.
  - A beat is accepted on each edge with in_valid & in_ready.
  - The stage-1 register captures {a, b, c, s, idx=vec_cnt}, and vec_cnt increments.
  - On the accept of vector NUM_VEC-1, go to DRAIN.
- Compare stage:
  - expected = zero-extended a + b + c, computed at WIDTH+1 bits; no overflow is possible.
  - Compared against the stage-1 copy of in_s.
  - Result is registered one edge after capture: err_cnt increments (saturating), mism_valid=1, mism_idx=idx.
  - Latency: mismatch reported in the cycle after the second edge following acceptance.
- DRAIN:
  - in_ready=0.
  - Stays 2 cycles until stage-1 and the compare register are empty, then DONE.
- DONE:
  - done=1; pass=(err_cnt==0).
  - Counters hold.
  - start -> RUN with counters cleared.
- start while in RUN or DRAIN is ignored.
- in_valid while not in RUN: the beat is not accepted, and no state changes.
- Back-to-back accepts every cycle are supported; there are no bubbles.
- rst_n asserted mid-run: run aborted, all state to reset values, and in-flight beats are discarded.
- err_cnt holds at 2**CNT_W-1 once reached.

Optional Feature:
- Macro: RCA_CHK_FIRST_FAIL_EN.
- When defined, three extra outputs are added:
  - ff_valid (1)
  - ff_idx (CNT_W)
  - ff_data ({a, b, c, s}, 3*WIDTH+2)
- ff_* capture the first mismatching vector of the run and hold until the next start or reset. ff_valid=1 from that capture onward.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package rca_chk_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the default WIDTH and CNT_W constants;
  - the packed beat struct {a, b, c, s, idx}.
- One sub-module, rca_chk_satcnt: a parameterised saturating counter with clear and inc. It is instantiated for err_cnt; vec_cnt uses the same module.

Test Plan:
- Reset then start; 20 beats with a correct s (e.g. a=4'd9, b=4'd7, c=1, s=5'd17) -> vec_cnt=20, err_cnt=0, done=1, pass=1, mism_valid never high.
- Corrupt vector 5 only (a=3, b=4, c=0, s=5'd8) -> single mism_valid pulse with mism_idx=5, two edges after accept; final err_cnt=1, pass=0.
- in_valid held high continuously through a run -> exactly 20 accepts, in_ready drops on the edge after the 20th accept, done asserts 2 cycles later.
- start pulsed in RUN and in_valid in IDLE -> no counter change and no restart; start in DONE -> counters clear and a new run begins.
- rst_n low mid-run after 7 accepts -> all outputs 0 and state IDLE immediately; a new run counts from 0.
- CNT_W=3, NUM_VEC=7, all vectors wrong -> err_cnt=7 (saturated); with RCA_CHK_FIRST_FAIL_EN, ff_idx=0 and ff_data matches vector 0.
